// File: rtl/wb_sevenseg_scan.sv
// Wishbone slave that scans four hex digits onto a multiplexed 7-segment display,
// with a blanking gap at the start of every digit slot to suppress ghosting.
module wb_sevenseg_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 16,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

  logic [15:0]   digits_q;
  logic [8:0]    ctrl_q;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic        req;
  logic        in_blank;
  logic        run;
  logic [3:0]  en_mask;
  logic [3:0]  dp_mask;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign req      = wb_stb_i & wb_cyc_i;
  assign run      = ctrl_q[8];
  assign en_mask  = ctrl_q[3:0];
  assign dp_mask  = ctrl_q[7:4];
  assign in_blank = (presc_q < BLANK_END);

  assign unused_bits = ^{wb_adr_i[31:4], wb_sel_i[3:2], wb_dat_i[31:16]};

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    rd_data = '0;
    case (wb_adr_i[3:0])
      4'h0:    rd_data = {16'b0, digits_q};
      4'h4:    rd_data = {23'b0, ctrl_q};
      4'h8:    rd_data = {29'b0, in_blank, idx_q};
      default: rd_data = '0;
    endcase
  end

  // Bus side: ack rises one cycle after a request is seen, and the write lands on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      digits_q <= 16'h0000;
      ctrl_q   <= 9'h10F;
    end else begin
      ack_q <= req & ~ack_q;
      if (req && !ack_q) begin
        dat_q <= rd_data;
        if (wb_we_i) begin
          case (wb_adr_i[3:0])
            4'h0: begin
              if (wb_sel_i[0]) digits_q[7:0]  <= wb_dat_i[7:0];
              if (wb_sel_i[1]) digits_q[15:8] <= wb_dat_i[15:8];
            end
            4'h4: begin
              if (wb_sel_i[0]) ctrl_q[7:0] <= wb_dat_i[7:0];
              if (wb_sel_i[1]) ctrl_q[8]   <= wb_dat_i[8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign wb_ack_o = req & ack_q;
  assign wb_dat_o = dat_q;

  // A disabled digit keeps its slot but stays fully dark, so the scan rate is unchanged.
  always_comb begin
    an_d  = 4'b0000;
    seg_d = 7'b0;
    dp_d  = 1'b0;
    if (run && !in_blank && en_mask[idx_q]) begin
      an_d  = 4'b0001 << idx_q;
      seg_d = hex_decode(digits_q[{idx_q, 2'b00} +: 4]);
      dp_d  = dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b0000;
      seg_q   <= 7'b0;
      dp_q    <= 1'b0;
    end else begin
      if (run) begin
        if (presc_q == PRESC_LAST) begin
          presc_q <= '0;
          idx_q   <= idx_q + 2'd1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = ACTIVE_LOW ? ~an_q  : an_q;
  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp  = ACTIVE_LOW ? ~dp_q  : dp_q;

endmodule

// File: tb/tb_wb_sevenseg_scan.sv
// Bench for wb_sevenseg_scan: read data and per-cycle pin states are queued as
// expectations when stimulus is applied and popped as the DUT produces them.
module tb_wb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [3:0]  wb_sel = 4'hF;
  logic [31:0] wb_dat_w = '0;
  logic        wb_ack;
  logic [31:0] wb_dat_r;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pin_t;

  logic [31:0] exp_rd[$];
  pin_t        pin_q[$];
  logic        ack_q[$];

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] seg_tbl [16];
  logic [15:0] digits_val;

  wb_sevenseg_scan #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wb_stb_i(wb_stb),
    .wb_cyc_i(wb_cyc),
    .wb_ack_o(wb_ack),
    .wb_we_i (wb_we),
    .wb_adr_i(wb_adr),
    .wb_sel_i(wb_sel),
    .wb_dat_i(wb_dat_w),
    .wb_dat_o(wb_dat_r),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  // Bus tasks are entered at a negedge and return at the negedge where ack was seen.
  task automatic wb_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
    wb_adr = addr; wb_we = 1'b0; wb_sel = 4'hF; wb_stb = 1'b1; wb_cyc = 1'b1;
    lat = -1; data = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        lat = i; data = wb_dat_r;
        break;
      end
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, output int lat);
    wb_adr = addr; wb_we = 1'b1; wb_sel = sel; wb_dat_w = data; wb_stb = 1'b1; wb_cyc = 1'b1;
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        lat = i;
        break;
      end
    end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic push_drive(input int d, input bit en, input bit dpv);
    pin_t e;
    for (int i = 0; i < 6; i++) begin
      if (en) e = '{an: 4'(1 << d), seg: seg_tbl[digits_val[4*d +: 4]], dp: dpv};
      else    e = '{an: 4'b0, seg: 7'b0, dp: 1'b0};
      pin_q.push_back(e);
    end
  endtask

  task automatic push_blank();
    for (int i = 0; i < 2; i++) pin_q.push_back('{an: 4'b0, seg: 7'b0, dp: 1'b0});
  endtask

  // Advances to the first drive cycle of digit 0 (previous cycle dark, an == 0001).
  task automatic wait_d0_start(output bit ok);
    logic [3:0] prev;
    prev = 4'hF; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev == 4'b0000 && an == 4'b0001) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int lat;
    repeat (3) @(negedge clk);
    n_total++;
    if ({an, seg, dp, wb_ack, wb_dat_r} !== 45'b0)
      $display("FAIL reset_state: an=%h seg=%h dp=%b ack=%b dat=%h, want all 0",
               an, seg, dp, wb_ack, wb_dat_r);
    else n_pass++;
    reset = 1'b0;
    // CTRL read, stb held one extra cycle to show ack is a single-cycle pulse
    exp_rd.push_back(32'h0000010F);
    wb_adr = 32'h4; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    lat = -1; d = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (wb_ack) begin lat = i; d = wb_dat_r; break; end
    end
    e = exp_rd.pop_front();
    n_total++;
    if (d !== e) $display("FAIL reset_ctrl: got %h want %h", d, e); else n_pass++;
    n_total++;
    if (lat != 1) $display("FAIL ack_latency: got %0d want 1", lat); else n_pass++;
    @(negedge clk);
    n_total++;
    if (wb_ack !== 1'b0) $display("FAIL ack_width: ack=%b want 0", wb_ack); else n_pass++;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    exp_rd.push_back(32'h0);
    wb_read(32'h0, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat != 1 || d !== e) $display("FAIL reset_digits: got %h lat %0d want %h lat 1", d, lat, e);
    else n_pass++;
    exp_rd.push_back(32'h0);
    wb_read(32'hC, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat < 0 || d !== e) $display("FAIL unmapped_read: got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_scan();
    logic [31:0] d, e;
    int lat;
    bit ok;
    pin_t p, x;
    wb_write(32'h0, 32'h0000A381, 4'b0011, lat);
    digits_val = 16'hA381;
    exp_rd.push_back(32'h0000A381);
    wb_read(32'h0, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat < 0 || d !== e) $display("FAIL digits_rb: got %h want %h", d, e); else n_pass++;
    for (int dg = 0; dg < 4; dg++) begin
      push_drive(dg, 1'b1, 1'b0);
      push_blank();
    end
    pin_q.push_back('{an: 4'b0001, seg: seg_tbl[digits_val[3:0]], dp: 1'b0});
    wait_d0_start(ok);
    n_total++;
    if (!ok) begin
      $display("FAIL scan_sync: digit0 drive phase not found");
      pin_q.delete();
    end else n_pass++;
    for (int k = 0; pin_q.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      x = pin_q.pop_front();
      p = '{an: an, seg: seg, dp: dp};
      n_total++;
      if (p !== x) $display("FAIL scan_pins[%0d]: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                            k, p.an, p.seg, p.dp, x.an, x.seg, x.dp);
      else n_pass++;
    end
  endtask

  task automatic test_run_stop();
    logic [31:0] d, e;
    int lat;
    // Entered at presc=3 idx=0; the write edge still advances to 4, then the scan holds.
    wb_write(32'h4, 32'h0000005D, 4'b0011, lat);
    @(negedge clk);
    n_total++;
    if ({an, seg, dp} !== 12'b0) $display("FAIL stop_dark: an=%h seg=%h dp=%b want 0", an, seg, dp);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      exp_rd.push_back(32'h0);
      wb_read(32'h8, d, lat);
      e = exp_rd.pop_front();
      n_total++;
      if (lat < 0 || d !== e || an !== 4'b0)
        $display("FAIL stop_status[%0d]: status %h an %h want status %h an 0", i, d, an, e);
      else n_pass++;
    end
  endtask

  task automatic test_disable_dp();
    int lat;
    bit ok;
    pin_t p, x;
    wb_write(32'h4, 32'h0000012B, 4'b0011, lat);
    push_drive(0, 1'b1, 1'b0);
    push_blank(); push_drive(1, 1'b1, 1'b1);
    push_blank(); push_drive(2, 1'b0, 1'b0);
    push_blank(); push_drive(3, 1'b1, 1'b0);
    push_blank();
    pin_q.push_back('{an: 4'b0001, seg: seg_tbl[digits_val[3:0]], dp: 1'b0});
    wait_d0_start(ok);
    n_total++;
    if (!ok) begin
      $display("FAIL mask_sync: digit0 drive phase not found");
      pin_q.delete();
    end else n_pass++;
    for (int k = 0; pin_q.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      x = pin_q.pop_front();
      p = '{an: an, seg: seg, dp: dp};
      n_total++;
      if (p !== x) $display("FAIL mask_pins[%0d]: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                            k, p.an, p.seg, p.dp, x.an, x.seg, x.dp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    int lat, cnt;
    bit ok;
    wb_write(32'h4, 32'h0000010F, 4'b0011, lat);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b0100) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL rst_sync: digit2 never driven"); else n_pass++;
    wb_adr = 32'h0; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({wb_ack, an, seg, dp} !== 13'b0)
      $display("FAIL rst_mid: ack=%b an=%h seg=%h dp=%b want 0", wb_ack, an, seg, dp);
    else n_pass++;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cnt = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (an == 4'b0001) begin cnt = i; break; end
    end
    n_total++;
    if (cnt != 3) $display("FAIL rst_first_an: got %0d clks want 3", cnt); else n_pass++;
    exp_rd.push_back(32'h0000010F);
    wb_read(32'h4, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat < 0 || d !== e) $display("FAIL rst_ctrl: got %h want %h", d, e); else n_pass++;
    exp_rd.push_back(32'h0);
    wb_read(32'h0, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat < 0 || d !== e) $display("FAIL rst_digits: got %h want %h", d, e); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    // index 0, in-blank set on the first cycle after release
    exp_rd.push_back(32'h00000004);
    wb_read(32'h8, d, lat);
    e = exp_rd.pop_front();
    n_total++;
    if (lat != 1 || d !== e) $display("FAIL rst_status: got %h lat %0d want %h", d, lat, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic got, want;
    wb_adr = 32'h4; wb_we = 1'b0; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(negedge clk);
    wb_stb = 1'b0;
    #1;
    n_total++;
    if (wb_ack !== 1'b0) $display("FAIL ack_drop: ack=%b want 0", wb_ack); else n_pass++;
    wb_cyc = 1'b0;
    @(negedge clk);
    ack_q.push_back(1'b0); ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b1);
    wb_stb = 1'b1; wb_cyc = 1'b1;
    for (int k = 0; ack_q.size() > 0; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got = wb_ack;
      want = ack_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL ack_pattern[%0d]: got %b want %b", k, got, want);
      else n_pass++;
    end
    @(negedge clk);
    wb_stb = 1'b0; wb_cyc = 1'b0;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    digits_val = 16'h0000;
    test_reset();
    test_scan();
    test_run_stop();
    test_disable_dp();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
